// File: rtl/bidir_pkg.sv
`default_nettype none
// =============================================================================
// Module   : bidir_pkg
// Purpose  : Shared state/direction encodings and counter sizing for the DAT port.
// Revision : 1.0
// =============================================================================
package bidir_pkg;

  localparam logic [1:0] ST_IN       = 2'd0;
  localparam logic [1:0] ST_TURN_OUT = 2'd1;
  localparam logic [1:0] ST_OUT      = 2'd2;
  localparam logic [1:0] ST_TURN_IN  = 2'd3;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Width needed to hold the value n (the counter loads the full gap length).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_sync.sv
`default_nettype none
// =============================================================================
// Module   : bidir_sync
// Purpose  : WIDTH-bit two-flop synchroniser, asynchronous active-low reset to 0.
// Revision : 1.0
// =============================================================================
module bidir_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/bidir_port_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : bidir_port_ctrl
// Purpose  : SD DAT tri-state port with a turnaround-gapped direction FSM.
//            Define BIDIR_INPUT_SYNC_EN to synchronise DATA before capture.
// Revision : 1.0
// =============================================================================
module bidir_port_ctrl
  import bidir_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             DIR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             WR_VALID,
  output logic             WR_READY,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             DIR_STATE,
  output logic             BUSY,
  inout  wire  [WIDTH-1:0] DATA
);

  localparam int              c_cnt_w     = cnt_width(TURN_CYCLES);
  localparam logic [c_cnt_w-1:0] c_turn_load = c_cnt_w'(TURN_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  logic [1:0]         state_q,   state_d;
  logic [c_cnt_w-1:0] cnt_q,     cnt_d;
  logic               oe_q,      oe_d;
  logic               dir_q,     dir_d;
  logic [WIDTH-1:0]   out_reg_q, out_reg_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               w_wr_fire;
  logic               w_in_now;
  logic [WIDTH-1:0]   w_cap_data;
  logic               w_cap_valid;

  // DIR_REQ is only looked at in the settled states; turns always run to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IN: begin
        if (DIR_REQ == DIR_OUT) begin
          state_d = ST_TURN_OUT;
          cnt_d   = c_turn_load;
        end
      end
      ST_TURN_OUT: begin
        if (cnt_q != '0) cnt_d = cnt_q - c_cnt_one;
        if (cnt_q <= c_cnt_one) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (DIR_REQ == DIR_IN) begin
          state_d = ST_TURN_IN;
          cnt_d   = c_turn_load;
        end
      end
      ST_TURN_IN: begin
        if (cnt_q != '0) cnt_d = cnt_q - c_cnt_one;
        if (cnt_q <= c_cnt_one) state_d = ST_IN;
      end
      default: begin
        state_d = ST_IN;
        cnt_d   = '0;
      end
    endcase
  end

  assign WR_READY  = (state_q == ST_OUT) & ~DIR_REQ;
  assign w_wr_fire = WR_READY & WR_VALID;
  assign w_in_now  = (state_q == ST_IN);

  always_comb begin
    oe_d      = (state_d == ST_OUT);
    out_reg_d = w_wr_fire ? WR_DATA : out_reg_q;
    dir_d     = dir_q;
    if (state_d == ST_IN)  dir_d = DIR_IN;
    if (state_d == ST_OUT) dir_d = DIR_OUT;
  end

`ifdef BIDIR_INPUT_SYNC_EN
  logic [WIDTH-1:0] w_sync_data;
  logic [1:0]       in_dly_q, in_dly_d;

  bidir_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_d   (DATA),
    .o_q   (w_sync_data)
  );

  // The IN flag travels alongside the data so validity matches the sample's origin.
  assign in_dly_d = {in_dly_q[0], w_in_now};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) in_dly_q <= '0;
    else          in_dly_q <= in_dly_d;
  end

  assign w_cap_data  = w_sync_data;
  assign w_cap_valid = in_dly_q[1];
`else
  assign w_cap_data  = DATA;
  assign w_cap_valid = w_in_now;
`endif

  always_comb begin
    rd_data_d  = w_cap_valid ? w_cap_data : rd_data_q;
    rd_valid_d = w_cap_valid;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IN;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      dir_q      <= DIR_IN;
      out_reg_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      dir_q      <= dir_d;
      out_reg_q  <= out_reg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign DATA      = oe_q ? out_reg_q : {WIDTH{1'bz}};
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign DIR_STATE = dir_q;
  assign BUSY      = (state_q == ST_TURN_OUT) | (state_q == ST_TURN_IN);

endmodule
`default_nettype wire

// File: tb/tb_bidir_port_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_bidir_port_ctrl
// Purpose  : Self-checking bench: directed scenarios plus random traffic vs a model.
// Revision : 1.0
// =============================================================================
module tb_bidir_port_ctrl;

  localparam int WIDTH = 4;
  localparam int TC    = 2;
`ifdef BIDIR_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             CLK      = 1'b0;
  logic             RESET_N  = 1'b0;
  logic             DIR_REQ  = 1'b1;
  logic [WIDTH-1:0] WR_DATA  = '0;
  logic             WR_VALID = 1'b0;
  wire              WR_READY;
  wire  [WIDTH-1:0] RD_DATA;
  wire              RD_VALID;
  wire              DIR_STATE;
  wire              BUSY;
  wire  [WIDTH-1:0] DATA;

  logic [WIDTH-1:0] ext_val = 4'hA;
  logic             run_chk = 1'b0;
  int               errors  = 0;
  int               checks  = 0;

  // Model: settled direction plus remaining turnaround cycles.
  logic             m_dir  = 1'b1;
  int               m_left = 0;
  logic [WIDTH-1:0] m_out  = '0;
  logic [WIDTH-1:0] m_rd   = '0;
  logic             m_rv   = 1'b0;
  logic [WIDTH-1:0] p_d [2];
  logic             p_v [2];
  logic [WIDTH-1:0] cap_d;
  logic             cap_v;
  logic             in_now;
  wire              exp_drive = (m_left == 0) && (m_dir == 1'b0);

  // Card side drives the bus whenever the host is expected to have released it.
  assign DATA = exp_drive ? {WIDTH{1'bz}} : ext_val;

  bidir_port_ctrl #(
    .WIDTH       (WIDTH),
    .TURN_CYCLES (TC)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .DIR_REQ   (DIR_REQ),
    .WR_DATA   (WR_DATA),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .DIR_STATE (DIR_STATE),
    .BUSY      (BUSY),
    .DATA      (DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
    #1;
  endtask

  // Reference model, advanced on each clock edge or async reset.
  initial begin
    p_d[0] = '0; p_d[1] = '0; p_v[0] = 1'b0; p_v[1] = 1'b0;
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        m_dir = 1'b1; m_left = 0; m_out = '0; m_rd = '0; m_rv = 1'b0;
        p_d[0] = '0; p_d[1] = '0; p_v[0] = 1'b0; p_v[1] = 1'b0;
      end else begin
        in_now = (m_left == 0) && (m_dir == 1'b1);
        if (LAT == 3) begin
          cap_d = p_d[1]; cap_v = p_v[1];
          p_d[1] = p_d[0]; p_v[1] = p_v[0];
          p_d[0] = ext_val; p_v[0] = in_now;
        end else begin
          cap_d = ext_val; cap_v = in_now;
        end
        if (cap_v) m_rd = cap_d;
        m_rv = cap_v;
        if (exp_drive && !DIR_REQ && WR_VALID) m_out = WR_DATA;
        if (m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_dir = ~m_dir;
        end else if (m_dir != DIR_REQ) begin
          m_left = TC;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (run_chk) begin
        chk1("m_busy",      BUSY,      m_left > 0);
        chk1("m_dir_state", DIR_STATE, m_dir);
        chk1("m_wr_ready",  WR_READY,  exp_drive && !DIR_REQ);
        chk1("m_rd_valid",  RD_VALID,  m_rv);
        chkw("m_rd_data",   RD_DATA,   m_rd);
        chkw("m_bus",       DATA,      exp_drive ? m_out : ext_val);
      end
    end
  end

  initial begin
    // Reset with the card driving 4'hA.
    repeat (3) @(posedge CLK);
    nxt();
    chkw("rst_bus_released", DATA, 4'hA);
    chk1("rst_rd_valid", RD_VALID, 1'b0);
    chkw("rst_rd_data", RD_DATA, 4'h0);
    chk1("rst_dir_state", DIR_STATE, 1'b1);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_wr_ready", WR_READY, 1'b0);
    run_chk = 1'b1;
    RESET_N = 1'b1;

    // Read.
    ext_val = 4'h5;
    repeat (LAT - 1) @(posedge CLK);
    nxt();
    chkw("read_data", RD_DATA, 4'h5);
    chk1("read_valid", RD_VALID, 1'b1);

    // Turn to output.
    DIR_REQ = 1'b0;
    nxt(); chk1("tout_busy1", BUSY, 1'b1); chkw("tout_bus1", DATA, 4'h5);
    nxt(); chk1("tout_busy2", BUSY, 1'b1); chkw("tout_bus2", DATA, 4'h5);
    nxt(); chk1("tout_busy_done", BUSY, 1'b0); chkw("tout_bus_drv", DATA, 4'h0);
    chk1("tout_wr_ready", WR_READY, 1'b1); chk1("tout_dir", DIR_STATE, 1'b0);

    // Single-cycle write then hold.
    WR_DATA = 4'hC; WR_VALID = 1'b1;
    nxt(); chkw("write_bus", DATA, 4'hC);
    WR_VALID = 1'b0; WR_DATA = 4'h3;
    nxt(); chkw("write_hold", DATA, 4'hC);

    // Back to input, then reverse in the middle of a TURN_OUT.
    DIR_REQ = 1'b1;
    nxt(); chk1("tin_busy", BUSY, 1'b1);
    nxt();
    nxt(); chk1("tin_done", BUSY, 1'b0); chk1("tin_dir", DIR_STATE, 1'b1);
    DIR_REQ = 1'b0;
    nxt(); chk1("rev_busy1", BUSY, 1'b1);
    DIR_REQ = 1'b1;
    nxt(); chk1("rev_busy2", BUSY, 1'b1);
    nxt(); chk1("rev_out_busy", BUSY, 1'b0); chk1("rev_out_ready", WR_READY, 1'b0);
    chkw("rev_out_bus", DATA, 4'hC); chk1("rev_out_dir", DIR_STATE, 1'b0);
    nxt(); chk1("rev_tin1", BUSY, 1'b1); chk1("rev_tin1_dir", DIR_STATE, 1'b0);
    nxt(); chk1("rev_tin2", BUSY, 1'b1);
    nxt(); chk1("rev_in", BUSY, 1'b0); chk1("rev_in_dir", DIR_STATE, 1'b1);

    // Reset while driving 4'hC.
    DIR_REQ = 1'b0;
    nxt(); nxt(); nxt();
    chkw("pre_rst_bus", DATA, 4'hC);
    ext_val = 4'hA;
    #1 RESET_N = 1'b0;
    #1;
    chkw("rst_out_released", DATA, 4'hA);
    chk1("rst_out_busy", BUSY, 1'b0);
    chk1("rst_out_dir", DIR_STATE, 1'b1);
    chk1("rst_out_ready", WR_READY, 1'b0);
    nxt();
    RESET_N = 1'b1;
    nxt(); nxt(); nxt();
    chkw("post_rst_bus", DATA, 4'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if ($urandom_range(0, 7) == 0) DIR_REQ = ~DIR_REQ;
      WR_VALID = 1'($urandom_range(0, 1));
      WR_DATA  = 4'($urandom);
      ext_val  = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        RESET_N = 1'b0;
        #1 RESET_N = 1'b1;
      end
    end

    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
